// File: rtl/alu_reg_wb.sv
// alu_reg_wb
// ----------------------------------------------------------------------------
// Register file and writeback stage for the 8-bit datapath.
//   - Sources both ALU operands (datA_out -> inA, datB_out -> inB) and the
//     carry-in (sc_out -> sc_i).
//   - Accepts the ALU result through a one-entry writeback pipeline register.
//   - Holds the architectural carry, zero and parity flags.
//
// Build option:
//   ALU_REG_WB_BYPASS_EN - when defined, a read whose address matches the
//                          pending writeback entry returns the pending data.
//
// Parameters:
//   W  - data width (ALU datapath width)
//   PW - register address width; the file holds 2**PW registers
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   wr_en       capture a register write this cycle
//   wr_addr     destination register
//   wr_data     write data (ALU rslt)
//   sc_wr_en    update the carry flag
//   sc_in       new carry (ALU sc_o)
//   flag_wr_en  update the zero and parity flags
//   zero_in     ALU zero
//   pari_in     ALU pari
//   rd_addrA    read address, port A
//   rd_addrB    read address, port B
//   datA_out    port A read data (combinational)
//   datB_out    port B read data (combinational)
//   sc_out      carry flag
//   zero_flag   registered zero flag
//   pari_flag   registered parity flag
//   wb_pending  a captured write has not yet committed to the array
// ----------------------------------------------------------------------------
module alu_reg_wb #(
    parameter int unsigned W  = 8,
    parameter int unsigned PW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          sc_wr_en,
    input  logic          sc_in,
    input  logic          flag_wr_en,
    input  logic          zero_in,
    input  logic          pari_in,
    input  logic [PW-1:0] rd_addrA,
    input  logic [PW-1:0] rd_addrB,
    output logic [W-1:0]  datA_out,
    output logic [W-1:0]  datB_out,
    output logic          sc_out,
    output logic          zero_flag,
    output logic          pari_flag,
    output logic          wb_pending
);

    localparam int unsigned NREG = 1 << PW;

    logic [W-1:0]  regs [NREG];

    logic          wb_valid;
    logic [PW-1:0] wb_addr;
    logic [W-1:0]  wb_data;

    // Register array: only the writeback entry ever writes it, so a write
    // lands one edge after it was captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Writeback entry. Commit above and capture here happen on the same edge,
    // so back-to-back writes flow through at one per cycle. Address and data
    // hold when nothing is captured; only the valid bit drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (wr_en) begin
            wb_valid <= 1'b1;
            wb_addr  <= wr_addr;
            wb_data  <= wr_data;
        end else begin
            wb_valid <= 1'b0;
        end
    end

    // Flags bypass the writeback pipeline so a carry chain sees the new
    // carry on the very next instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc_out    <= 1'b0;
            zero_flag <= 1'b0;
            pari_flag <= 1'b0;
        end else begin
            if (sc_wr_en) begin
                sc_out <= sc_in;
            end
            if (flag_wr_en) begin
                zero_flag <= zero_in;
                pari_flag <= pari_in;
            end
        end
    end

    assign wb_pending = wb_valid;

    // Read ports
    always_comb begin
        datA_out = regs[rd_addrA];
        datB_out = regs[rd_addrB];
`ifdef ALU_REG_WB_BYPASS_EN
        // Forward the not-yet-committed value so a consumer can issue
        // immediately after its producer.
        if (wb_valid && (rd_addrA == wb_addr)) begin
            datA_out = wb_data;
        end
        if (wb_valid && (rd_addrB == wb_addr)) begin
            datB_out = wb_data;
        end
`endif
    end

endmodule
